// File: rtl/grb_ws2812_tx.sv
// WS2812 transmitter: scales/saturates 60-bit accumulator pixels to 24-bit GRB, buffers them
// in a small FIFO and serialises frames (N_LED pixels followed by a latch gap) onto dout.
module grb_ws2812_tx #(
  parameter int SHIFT  = 4,
  parameter int N_LED  = 32,
  parameter int DEPTH  = 8,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 63,
  parameter int TRESET = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [59:0] GRBdata,
  input  logic        ok,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic        underrun
);

  // state | meaning
  // IDLE  | line low, waiting for a buffered pixel
  // LOAD  | pop a pixel into the shift register (first pixel or after a stall)
  // SEND  | emitting bits MSB first, one TBIT-cycle slot each
  // WAIT  | FIFO ran dry mid-frame; line low until data or latch timeout
  // LATCH | line low for TRESET cycles to latch the frame
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_LATCH} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2((TRESET > TBIT) ? TRESET : TBIT);
  localparam int PW = $clog2(N_LED + 1);

  function automatic logic [7:0] sat(input logic [19:0] c);
    logic [19:0] s;
    s = c >> SHIFT;
    return (s > 20'd255) ? 8'hFF : s[7:0];
  endfunction

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ok_d, push_req, wr_en, pop, empty, full;
  logic [23:0]   word, rd_data;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n, hi_lim;
  logic [4:0]    bit_idx, bit_n;
  logic [PW-1:0] pix, pix_n;
  logic [23:0]   shreg, shreg_n;
  logic          dout_n, set_under;

  assign word     = {sat(GRBdata[59:40]), sat(GRBdata[39:20]), sat(GRBdata[19:0])};
  assign push_req = ok & ~ok_d;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign wr_en    = rst & push_req & (~full | pop);
  assign rd_data  = mem[rd_ptr];
  assign hi_lim   = shreg[bit_idx] ? TW'(T1H) : TW'(T0H);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ok_d     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
      dout     <= 1'b0;
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      pix      <= '0;
      shreg    <= '0;
    end else begin
      ok_d <= ok;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      if (set_under) underrun <= 1'b1;
      dout    <= dout_n;
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_n;
      pix     <= pix_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    bit_n      = bit_idx;
    pix_n      = pix;
    shreg_n    = shreg;
    pop        = 1'b0;
    dout_n     = 1'b0;
    set_under  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_n = S_LOAD;
          pix_n   = '0;
        end
      end
      S_LOAD: begin
        pop     = 1'b1;
        shreg_n = rd_data;
        bit_n   = 5'd23;
        timer_n = '0;
        state_n = S_SEND;
      end
      S_SEND: begin
        dout_n = (timer < hi_lim);
        if (timer == TW'(TBIT - 1)) begin
          timer_n = '0;
          if (bit_idx != 5'd0) begin
            bit_n = bit_idx - 5'd1;
          end else if (pix == PW'(N_LED - 1)) begin
            state_n = S_LATCH;
          end else begin
            pix_n = pix + PW'(1);
            // Reload in the final slot cycle so consecutive pixels run gap-free.
            if (!empty) begin
              pop     = 1'b1;
              shreg_n = rd_data;
              bit_n   = 5'd23;
            end else begin
              set_under = 1'b1;
              state_n   = S_WAIT;
            end
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_WAIT: begin
        if (!empty) begin
          state_n = S_LOAD;
        end else if (timer == TW'(TRESET - 1)) begin
          frame_done = 1'b1;
          state_n    = S_IDLE;
          timer_n    = '0;
          pix_n      = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_LATCH: begin
        if (timer == TW'(TRESET - 1)) begin
          frame_done = 1'b1;
          state_n    = S_IDLE;
          timer_n    = '0;
          pix_n      = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_grb_ws2812_tx.sv
// Self-checking bench for grb_ws2812_tx: decodes the WS2812 waveform back into pixels and
// compares them in order against a queue of expected GRB words built from the scaling rule.
module tb_grb_ws2812_tx;

  localparam int SHIFT  = 4;
  localparam int N_LED  = 4;
  localparam int DEPTH  = 8;
  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int TBIT   = 63;
  localparam int TRESET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [59:0] GRBdata = '0;
  logic        ok = 1'b0;
  logic        dout, busy, frame_done, overflow, underrun;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_q [$];
  int          frame_px [$];

  grb_ws2812_tx #(
    .SHIFT(SHIFT), .N_LED(N_LED), .DEPTH(DEPTH), .T0H(T0H),
    .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .clk(clk), .rst(rst), .GRBdata(GRBdata), .ok(ok), .dout(dout),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [59:0] d);
    int unsigned ch [3];
    logic [23:0] w;
    ch[0] = d[59:40];
    ch[1] = d[39:20];
    ch[2] = d[19:0];
    w = '0;
    for (int i = 0; i < 3; i++) begin
      ch[i] = ch[i] / (1 << SHIFT);
      if (ch[i] > 255) ch[i] = 255;
      w = {w[15:0], 8'(ch[i])};
    end
    return w;
  endfunction

  function automatic logic [59:0] rand_pixel();
    logic [19:0] g, r, b;
    g = 20'($urandom_range(0, 5000));
    r = 20'($urandom_range(0, 5000));
    b = 20'($urandom_range(0, 5000));
    return {g, r, b};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: turns the dout waveform into bits/pixels and frames.
  int          cyc = 0;
  logic        prev = 1'b0;
  int          hi_cnt = 0, low_run = 0, bit_cnt = 0, last_rise = 0;
  int          pix_rx = 0, done_cnt = 0, pix_in_frame = 0;
  logic [23:0] acc = '0;

  always @(negedge clk) begin
    logic [23:0] want;
    cyc++;
    if (!rst) begin
      prev = 1'b0; hi_cnt = 0; low_run = 0; bit_cnt = 0; pix_in_frame = 0;
    end else begin
      if (dout && !prev) begin
        if (bit_cnt > 0) check("bit_period", cyc - last_rise, TBIT);
        last_rise = cyc;
        hi_cnt = 1;
      end else if (dout) begin
        hi_cnt++;
      end
      if (!dout && prev) begin
        checks++;
        if (hi_cnt == T1H) acc = {acc[22:0], 1'b1};
        else if (hi_cnt == T0H) acc = {acc[22:0], 1'b0};
        else begin
          failures++;
          $display("FAIL bit_width got=%0d want=%0d or %0d", hi_cnt, T0H, T1H);
          acc = {acc[22:0], 1'b0};
        end
        bit_cnt++;
        if (bit_cnt == 24) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pixel_unexpected got=%06h want=none", acc);
          end else begin
            want = exp_q.pop_front();
            if (acc !== want) begin
              failures++;
              $display("FAIL pixel_data got=%06h want=%06h", acc, want);
            end
          end
          bit_cnt = 0;
          pix_rx++;
          pix_in_frame++;
        end
      end
      low_run = dout ? 0 : low_run + 1;
      if (frame_done) begin
        checks++;
        if (low_run < TRESET || bit_cnt != 0) begin
          failures++;
          $display("FAIL frame_done_early got=low%0d,bits%0d want=low>=%0d,bits0",
                   low_run, bit_cnt, TRESET);
        end
        frame_px.push_back(pix_in_frame);
        pix_in_frame = 0;
        done_cnt++;
      end
      prev = dout;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ok  = 1'b0;
    cycles(2);
    exp_q.delete();
    frame_px.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One ok strobe held for 'hold' cycles; GRBdata changes while held and must be ignored.
  task automatic strobe(input logic [59:0] d, input int hold, input bit accepted);
    @(negedge clk);
    GRBdata = d;
    ok = 1'b1;
    if (accepted) exp_q.push_back(model(d));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      GRBdata = rand_pixel();
    end
    @(negedge clk);
    ok = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, done_cnt >= target ? 1 : 0, 1);
  endtask

  task automatic chk_frame(input string name, input int want);
    if (frame_px.size() == 0) check(name, -1, want);
    else check(name, frame_px.pop_front(), want);
  endtask

  initial begin
    int base, n, lat;
    bit stayed_low;

    // Reset holds everything low even with ok toggling.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ok = ~ok;
      GRBdata = rand_pixel();
    end
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_underrun", int'(underrun), 0);
    ok = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycles(20);
    check("rst_no_push", int'(busy), 0);

    // Single pixel: bytes FF,01,00; first rising edge 3 edges after ok is captured.
    do_reset();
    base = done_cnt;
    @(negedge clk);
    GRBdata = {20'h00FF0, 20'h00010, 20'h00000};
    ok = 1'b1;
    exp_q.push_back(24'hFF0100);
    check("model_single", int'(model(GRBdata)), 24'hFF0100);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) ok = 1'b0;
      if (dout) lat = i;
    end
    // ok sampled at edge 1, dout updated at edge 4, seen on the 4th negedge.
    check("latency_edges", lat - 1, 3);
    wait_done(base + 1, 6000, "single_done");
    chk_frame("single_frame_px", 1);
    check("single_underrun", int'(underrun), 1);
    cycles(50);
    check("single_one_done", done_cnt, base + 1);
    check("single_idle", int'(busy), 0);

    // Saturation, ok held high, overflow with one in flight plus 8 buffered.
    do_reset();
    base = done_cnt;
    strobe({20'hFFFFF, 20'h01000, 20'h00FFF}, 3, 1'b1);
    check("sat_word", int'(model({20'hFFFFF, 20'h01000, 20'h00FFF})), 24'hFFFFFF);
    cycles(6);
    check("ovf_before", int'(overflow), 0);
    strobe({20'h00100, 20'h00FF0, 20'h00020}, 1, 1'b1);
    for (int i = 1; i < 8; i++) strobe(rand_pixel(), 1 + (i % 2), 1'b1);
    check("ovf_full_not_yet", int'(overflow), 0);
    strobe(rand_pixel(), 1, 1'b0);
    check("ovf_set", int'(overflow), 1);
    wait_done(base + 3, 30000, "ovf_frames_done");
    chk_frame("ovf_frame1", 4);
    chk_frame("ovf_frame2", 4);
    chk_frame("ovf_frame3", 1);
    check("ovf_all_sent", exp_q.size(), 0);

    // Underrun with a short gap: frame completes with 4 pixels then latches.
    do_reset();
    base = done_cnt;
    n = pix_rx;
    strobe(rand_pixel(), 1, 1'b1);
    strobe(rand_pixel(), 1, 1'b1);
    for (int i = 0; i < 5000 && pix_rx < n + 2; i++) @(negedge clk);
    check("ur_two_sent", pix_rx - n, 2);
    stayed_low = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dout) stayed_low = 1'b0;
    end
    check("ur_gap_low", int'(stayed_low), 1);
    check("ur_flag", int'(underrun), 1);
    check("ur_still_busy", int'(busy), 1);
    strobe(rand_pixel(), 1, 1'b1);
    strobe(rand_pixel(), 1, 1'b1);
    wait_done(base + 1, 12000, "ur_done");
    chk_frame("ur_frame_px", 4);

    // Underrun gap beyond the latch time: frame closes early, new frame follows.
    do_reset();
    base = done_cnt;
    strobe(rand_pixel(), 1, 1'b1);
    strobe(rand_pixel(), 2, 1'b1);
    wait_done(base + 1, 8000, "ur_long_done1");
    chk_frame("ur_long_px1", 2);
    strobe(rand_pixel(), 1, 1'b1);
    strobe(rand_pixel(), 1, 1'b1);
    wait_done(base + 2, 8000, "ur_long_done2");
    chk_frame("ur_long_px2", 2);

    // Reset in the middle of bit 10 aborts and empties the FIFO.
    do_reset();
    base = done_cnt;
    n = pix_rx;
    strobe(rand_pixel(), 1, 1'b1);
    strobe(rand_pixel(), 1, 1'b1);
    for (int i = 0; i < 2000 && !(bit_cnt == 10 && dout); i++) @(negedge clk);
    check("mid_reached_bit10", bit_cnt, 10);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_busy", int'(busy), 0);
    exp_q.delete();
    rst = 1'b1;
    stayed_low = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dout || busy) stayed_low = 1'b0;
    end
    check("mid_fifo_empty", int'(stayed_low), 1);
    check("mid_no_pixels", pix_rx - n, 0);
    strobe(rand_pixel(), 1, 1'b1);
    wait_done(base + 1, 6000, "mid_restart_done");
    chk_frame("mid_restart_px", 1);

    // Random pixels, random hold lengths, two full frames through LATCH.
    do_reset();
    base = done_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < N_LED; p++) begin
        strobe(rand_pixel(), $urandom_range(1, 3), 1'b1);
        cycles($urandom_range(1, 4));
      end
      wait_done(base + f + 1, 12000, "rand_done");
      chk_frame("rand_frame_px", N_LED);
    end
    check("rand_underrun", int'(underrun), 0);
    check("rand_overflow", int'(overflow), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
